// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector link (transmit side).
// The preamble is transmitted starting from bit 0.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_GUARD = 3'd4
   } seq_tx_state_t;

   localparam logic [5:0] SEQ_PREAMBLE     = 6'b011110;
   localparam int         SEQ_PREAMBLE_LEN = 6;

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int seq_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-time divider: bit_tick_o marks the last clock of each serial bit time.
// tick_next_o predicts whether the following cycle will carry a tick.
module seq_bit_tick
   import seq_pkg::*;
#(
   parameter int BIT_DIV = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic run_i,
   output logic bit_tick_o,
   output logic tick_next_o
);

   localparam int            CW   = seq_cnt_w(BIT_DIV);
   localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !run_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick_o  = run_i && (cnt_q == LAST);
   assign tick_next_o = (cnt_d == LAST);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: idle-high line, preamble, fixed-length payload, guard.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
   import seq_pkg::*;
#(
   parameter int PAYLOAD_BITS = 1024,
   parameter int WORD_W       = 8,
   parameter int BIT_DIV      = 1,
   parameter int GUARD_BITS   = 2
) (
   input  logic              FPGAclk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              serOut,
   output logic              serOutEn,
   output logic              busy,
   output logic              frame_done,
   output logic              underrun
);

   localparam int WORDS = PAYLOAD_BITS / WORD_W;
   localparam int BCW   = $clog2(PAYLOAD_BITS + 1);
   localparam int WCW   = $clog2(WORDS + 1);
   localparam int IBW   = seq_cnt_w(WORD_W);
   localparam int GCW   = seq_cnt_w(GUARD_BITS);

   localparam logic [BCW-1:0] BIT_LAST = BCW'(PAYLOAD_BITS - 1);
   localparam logic [WCW-1:0] WORDS_C  = WCW'(WORDS);
   localparam logic [IBW-1:0] IB_LAST  = IBW'(WORD_W - 1);
   localparam logic [GCW-1:0] G_LAST   = GCW'(GUARD_BITS - 1);
   localparam logic [2:0]     PRE_LAST = 3'(SEQ_PREAMBLE_LEN - 1);

   seq_tx_state_t state_q, state_d;
   logic [2:0]        pre_idx_q, pre_idx_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]    word_cnt_q, word_cnt_d;
   logic [IBW-1:0]    wbit_q, wbit_d;
   logic [GCW-1:0]    guard_q, guard_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [WORD_W-1:0] wbuf_q, wbuf_d;
   logic              wbuf_valid_q, wbuf_valid_d;
   logic              par_q, par_d;
   logic              ser_q, ser_d;
   logic              en_q, en_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              under_q, under_d;

   logic bit_tick, tick_next, clear, accept, load;

   seq_bit_tick #(.BIT_DIV(BIT_DIV)) u_tick (
      .clk_i       (FPGAclk),
      .rst_ni      (rst),
      .clear_i     (clear),
      .run_i       (state_q != ST_IDLE),
      .bit_tick_o  (bit_tick),
      .tick_next_o (tick_next)
   );

   always_comb begin
      state_d      = state_q;
      pre_idx_d    = pre_idx_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      wbit_d       = wbit_q;
      guard_d      = guard_q;
      shreg_d      = shreg_q;
      wbuf_d       = wbuf_q;
      wbuf_valid_d = wbuf_valid_q;
      par_d        = par_q;
      ser_d        = ser_q;
      en_d         = en_q;
      under_d      = under_q;
      clear        = 1'b0;
      load         = 1'b0;
      accept       = word_valid && ready_q;

      // ready is only raised while the buffer is empty, so a transfer never overwrites
      if (accept) begin
         word_cnt_d   = word_cnt_q + 1'b1;
         wbuf_d       = word_data;
         wbuf_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            ser_d = 1'b1;
            en_d  = 1'b0;
            if (start) begin
               state_d      = ST_PRE;
               pre_idx_d    = '0;
               ser_d        = SEQ_PREAMBLE[0];
               en_d         = 1'b1;
               under_d      = 1'b0;
               bit_cnt_d    = '0;
               word_cnt_d   = '0;
               wbit_d       = '0;
               guard_d      = '0;
               wbuf_valid_d = 1'b0;
               par_d        = 1'b0;
               clear        = 1'b1;
            end
         end
         ST_PRE: begin
            if (bit_tick) begin
               if (pre_idx_q == PRE_LAST) begin
                  state_d = ST_DATA;
                  load    = 1'b1;
               end else begin
                  pre_idx_d = pre_idx_q + 3'd1;
                  ser_d     = SEQ_PREAMBLE[pre_idx_d];
               end
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               par_d     = par_q ^ ser_q;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                  state_d = ST_PAR;
                  ser_d   = par_d;
                  en_d    = 1'b1;
`else
                  state_d = ST_GUARD;
                  ser_d   = 1'b1;
                  en_d    = 1'b0;
                  guard_d = '0;
`endif
               end else if (wbit_q == IB_LAST) begin
                  load = 1'b1;
               end else begin
                  shreg_d = shreg_q >> 1;
                  ser_d   = shreg_q[1];
                  wbit_d  = wbit_q + 1'b1;
               end
            end
         end
`ifdef SEQ_TX_PARITY_EN
         ST_PAR: begin
            if (bit_tick) begin
               state_d = ST_GUARD;
               ser_d   = 1'b1;
               en_d    = 1'b0;
               guard_d = '0;
            end
         end
`endif
         ST_GUARD: begin
            if (bit_tick) begin
               if (guard_q == G_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  guard_d = guard_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            ser_d   = 1'b1;
            en_d    = 1'b0;
         end
      endcase

      // An empty buffer at load time costs the slot: zeros go out, the frame never stalls
      if (load) begin
         wbit_d = '0;
         if (wbuf_valid_q) begin
            shreg_d = wbuf_q;
         end else begin
            shreg_d = '0;
            under_d = 1'b1;
         end
         ser_d        = shreg_d[0];
         wbuf_valid_d = accept;
      end

      ready_d = ((state_d == ST_PRE) || (state_d == ST_DATA)) && !wbuf_valid_d
                && (word_cnt_d < WORDS_C);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_GUARD) && (guard_d == G_LAST) && tick_next;
   end

   always_ff @(posedge FPGAclk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         pre_idx_q    <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         wbit_q       <= '0;
         guard_q      <= '0;
         shreg_q      <= '0;
         wbuf_q       <= '0;
         wbuf_valid_q <= 1'b0;
         par_q        <= 1'b0;
         ser_q        <= 1'b1;
         en_q         <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         under_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_idx_q    <= pre_idx_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         wbit_q       <= wbit_d;
         guard_q      <= guard_d;
         shreg_q      <= shreg_d;
         wbuf_q       <= wbuf_d;
         wbuf_valid_q <= wbuf_valid_d;
         par_q        <= par_d;
         ser_q        <= ser_d;
         en_q         <= en_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         under_q      <= under_d;
      end
   end

   assign word_ready = ready_q;
   assign serOut     = ser_q;
   assign serOutEn   = en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign underrun   = under_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: a frame-level model predicts every line cycle,
// plus literal bit patterns and timings for the directed scenarios.
module tb_seq_frame_tx;

   localparam int P = 16;
`ifdef SEQ_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB  = 6 + P + PB + 2;
   localparam int NEN = 6 + P + PB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, start_b;
   logic [7:0] word_data_a, word_data_b;
   logic       word_valid_a, word_valid_b;
   logic       word_ready_a, word_ready_b;
   logic       serOut_a, serOut_b, serOutEn_a, serOutEn_b;
   logic       busy_a, busy_b, frame_done_a, frame_done_b, underrun_a, underrun_b;

   seq_frame_tx #(.PAYLOAD_BITS(P), .WORD_W(8), .BIT_DIV(1), .GUARD_BITS(2)) dut_a (
      .FPGAclk(clk), .rst(rst), .start(start_a), .word_data(word_data_a),
      .word_valid(word_valid_a), .word_ready(word_ready_a), .serOut(serOut_a),
      .serOutEn(serOutEn_a), .busy(busy_a), .frame_done(frame_done_a), .underrun(underrun_a)
   );

   seq_frame_tx #(.PAYLOAD_BITS(P), .WORD_W(8), .BIT_DIV(3), .GUARD_BITS(2)) dut_b (
      .FPGAclk(clk), .rst(rst), .start(start_b), .word_data(word_data_b),
      .word_valid(word_valid_b), .word_ready(word_ready_b), .serOut(serOut_b),
      .serOutEn(serOutEn_b), .busy(busy_b), .frame_done(frame_done_b), .underrun(underrun_b)
   );

   int n_chk = 0;
   int n_pass = 0;
   int mon_t = 0;
   bit mon_on = 0;
   bit sel = 0;
   int frames = 0;
   logic [7:0] exp_w [2];
   bit exp_miss [2];
   bit exp_under;
   bit seq [0:63];
   bit cap [0:63];
   logic [7:0] src_q [$];
   bit xfer = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0d actual=%0h required=%0h", nm, mon_t, act, exp);
   endtask

   // Frame model: preamble, payload words LSB first (missing slots are zeros), parity, guard.
   task automatic build_seq();
      bit pre [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int pos = 0;
      bit p = 0;
      bit v;
      for (int i = 0; i < 6; i++) begin seq[pos] = pre[i]; pos++; end
      for (int s = 0; s < 2; s++)
         for (int b = 0; b < 8; b++) begin
            v = exp_miss[s] ? 1'b0 : exp_w[s][b];
            seq[pos] = v; p ^= v; pos++;
         end
      if (PB == 1) begin seq[pos] = p; pos++; end
      for (int g = 0; g < 2; g++) begin seq[pos] = 1'b1; pos++; end
      exp_under = exp_miss[0] | exp_miss[1];
   endtask

   function automatic logic [31:0] packcap(input int from, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = cap[from + i];
      return r;
   endfunction

   // Word source for dut_a: offers the queue head, pops on an observed transfer.
   always @(negedge clk) xfer = word_valid_a && word_ready_a;
   always @(posedge clk) begin
      #1;
      if (xfer && src_q.size() > 0) void'(src_q.pop_front());
      word_valid_a = (src_q.size() > 0);
      word_data_a  = (src_q.size() > 0) ? src_q[0] : 8'h00;
   end

   int   m_bd, m_tot, m_idx;
   logic e_ser, e_en, e_busy, e_done;
   logic o_ser, o_en, o_busy, o_done, o_und, o_start;

   always @(negedge clk) begin
      if (mon_on) begin
         m_bd  = sel ? 3 : 1;
         m_tot = NB * m_bd;
         o_ser = sel ? serOut_b : serOut_a;
         o_en  = sel ? serOutEn_b : serOutEn_a;
         o_busy = sel ? busy_b : busy_a;
         o_done = sel ? frame_done_b : frame_done_a;
         o_und  = sel ? underrun_b : underrun_a;
         o_start = sel ? start_b : start_a;
         if (mon_t == 0) build_seq();
         if (mon_t < m_tot) begin
            m_idx  = mon_t / m_bd;
            e_ser  = seq[m_idx];
            e_en   = (m_idx < NEN);
            e_busy = 1'b1;
            e_done = (mon_t == m_tot - 1);
            if (mon_t % m_bd == 0) cap[m_idx] = o_ser;
         end else begin
            e_ser = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         end
         chk("serOut", o_ser, e_ser);
         chk("serOutEn", o_en, e_en);
         chk("busy", o_busy, e_busy);
         chk("frame_done", o_done, e_done);
         if (mon_t == 0) chk("underrun_cleared", o_und, 1'b0);
         if (mon_t == m_tot - 1) chk("underrun_end", o_und, exp_under);
         if (mon_t == m_tot) begin
            frames++;
            if (o_start) mon_t = 0;
            else mon_on = 0;
         end else begin
            mon_t++;
         end
      end
   end

   task automatic start_frame(input bit which, input bit hold);
      @(posedge clk); #1;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      mon_t  = 0;
      mon_on = 1;
   endtask

   task automatic wait_frames(input int target);
      int lim = 0;
      while (frames < target && lim < 2000) begin @(posedge clk); #1; lim++; end
      if (frames < target) chk("frame_timeout", frames, target);
   endtask

   task automatic wait_t(input int n);
      int lim = 0;
      while (!(mon_on && mon_t == n) && lim < 2000) begin @(posedge clk); #1; lim++; end
      if (!(mon_on && mon_t == n)) chk("cycle_timeout", mon_t, n);
   endtask

   task automatic set_exp(input logic [7:0] w0, input logic [7:0] w1, input bit m1);
      exp_w[0] = w0; exp_w[1] = w1; exp_miss[0] = 1'b0; exp_miss[1] = m1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      word_valid_a = 1'b0; word_data_a = 8'h00;
      word_valid_b = 1'b1; word_data_b = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_serOut", serOut_a, 1'b1);
      chk("rst_serOutEn", serOutEn_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_word_ready", word_ready_a, 1'b0);
      chk("rst_underrun", underrun_a, 1'b0);
      chk("rst_serOut_b", serOut_b, 1'b1);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Both words available during the preamble
      set_exp(8'hA5, 8'h3C, 1'b0);
      src_q.push_back(8'hA5); src_q.push_back(8'h3C);
      base = frames;
      start_frame(1'b0, 1'b0);
      wait_frames(base + 1);
      chk("t1_bits", packcap(0, 22), {16'h3CA5, 6'b011110});
      chk("t1_guard", {cap[NB-2], cap[NB-1]}, 2'b11);
`ifdef SEQ_TX_PARITY_EN
      chk("t1_parity", cap[22], 1'b0);
`endif

      // Second word withheld: zero fill and sticky underrun
      set_exp(8'hA5, 8'h00, 1'b1);
      src_q.push_back(8'hA5);
      base = frames;
      start_frame(1'b0, 1'b0);
      wait_frames(base + 1);
      chk("t2_bits", packcap(6, 16), 16'h00A5);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_underrun_held", underrun_a, 1'b1);

      // Next start clears underrun; odd number of ones
      set_exp(8'hA5, 8'h3D, 1'b0);
      src_q.push_back(8'hA5); src_q.push_back(8'h3D);
      base = frames;
      start_frame(1'b0, 1'b0);
      wait_frames(base + 1);
      chk("t3_bits", packcap(6, 16), 16'h3DA5);
`ifdef SEQ_TX_PARITY_EN
      chk("t3_parity", cap[22], 1'b1);
`endif

      // start pulses during DATA and in the last GUARD cycle are ignored
      set_exp(8'h0F, 8'hF0, 1'b0);
      src_q.push_back(8'h0F); src_q.push_back(8'hF0);
      base = frames;
      start_frame(1'b0, 1'b0);
      wait_t(12);
      start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
      wait_t(NB - 1);
      start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
      wait_frames(base + 1);
      chk("t4_bits", packcap(6, 16), 16'hF00F);

      // Reset mid-payload, then a clean frame
      set_exp(8'h3C, 8'hA5, 1'b0);
      src_q.push_back(8'h3C); src_q.push_back(8'hA5);
      start_frame(1'b0, 1'b0);
      wait_t(10);
      mon_on = 0;
      rst = 1'b0;
      #1;
      chk("mid_rst_serOut", serOut_a, 1'b1);
      chk("mid_rst_serOutEn", serOutEn_a, 1'b0);
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_word_ready", word_ready_a, 1'b0);
      chk("mid_rst_frame_done", frame_done_a, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      src_q.delete();
      set_exp(8'h96, 8'h0F, 1'b0);
      src_q.push_back(8'h96); src_q.push_back(8'h0F);
      base = frames;
      start_frame(1'b0, 1'b0);
      wait_frames(base + 1);
      chk("t5_bits", packcap(0, 22), {16'h0F96, 6'b011110});

      // start held high: back-to-back frames
      set_exp(8'hC3, 8'h81, 1'b0);
      src_q.push_back(8'hC3); src_q.push_back(8'h81);
      src_q.push_back(8'hC3); src_q.push_back(8'h81);
      base = frames;
      start_frame(1'b0, 1'b1);
      wait_frames(base + 1);
      start_a = 1'b0;
      wait_frames(base + 2);
      chk("t6_bits", packcap(6, 16), 16'h81C3);

      // BIT_DIV = 3 instance
      repeat (2) @(posedge clk);
      sel = 1;
      set_exp(8'h5A, 8'h5A, 1'b0);
      base = frames;
      start_frame(1'b1, 1'b0);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (frame_done_b) break;
      end
`ifdef SEQ_TX_PARITY_EN
      chk("t7_done_cycle", n, 75);
`else
      chk("t7_done_cycle", n, 72);
`endif
      wait_frames(base + 1);
      sel = 0;

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter: the sending end of the sequence-detector link. It drives the line idle-high, emits the 6-bit preamble 0,1,1,1,1,0, then serializes exactly PAYLOAD_BITS payload bits pulled from a parallel word interface, and finishes with a high guard interval. It sits between the word source and the serial line that feeds the detector's serIn.

## Interface
- PAYLOAD_BITS, 1024: payload bits per frame; must be a multiple of WORD_W.
- WORD_W, 8: parallel word width.
- BIT_DIV, 1: FPGAclk cycles per serial bit (≥1).
- GUARD_BITS, 2: idle-high bit times after the payload (≥1).
- FPGAclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- word_data  in  WORD_W  payload word; sent LSB first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  block accepts word this cycle (transfer when valid & ready).
- serOut  out  1  serial line.
- serOutEn  out  1  high while preamble, payload and parity bits are driven.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse on the last guard cycle.
- underrun  out  1  sticky; set on payload starvation, cleared by next accepted start.

## Operation
- States: IDLE, PRE, DATA, (PAR), GUARD.
- IDLE: serOut=1, serOutEn=0, word_ready=0. start=1 → PRE; clears underrun, bit/word counters and the word buffer.
- PRE: sends preamble bits 0..5 = 0,1,1,1,1,0, each for BIT_DIV cycles → DATA.
- DATA: shifts out the shift register LSB first. A 1-entry word buffer refills it. word_ready = buffer empty AND words_requested < PAYLOAD_BITS/WORD_W; asserted from PRE entry onward, so the first word may arrive during the preamble.
- Shift register load: when the current word's last bit time ends, or at DATA entry, from the buffer. If the buffer is empty then, the word is replaced by all-zero bits and underrun is set. The frame never stalls, because the receiver counts bits. A late word arriving after its slot is accepted as the next word slot.
- After PAYLOAD_BITS bits: → PAR if compiled in, else → GUARD.
- GUARD: serOut=1, serOutEn=0 for GUARD_BITS bit times. frame_done pulses in the final cycle → IDLE. start is ignored in every state except IDLE.
- Counters: bit_cnt is $clog2(PAYLOAD_BITS+1) bits wide and word_cnt is $clog2(PAYLOAD_BITS/WORD_W+1) bits wide. The bit-time divider wraps at BIT_DIV-1. No counter wraps within a frame.
- Reset asynchronously forces IDLE mid-frame: serOut=1, serOutEn=0, word_ready=0, busy=0, frame_done=0, underrun=0, buffer empty, all counters 0.

## Timing
- start sampled high at edge k → PRE entered at k, first preamble bit on serOut from cycle k+1. Total frame length is (6+PAYLOAD_BITS[+1]+GUARD_BITS)·BIT_DIV cycles after k.
- All outputs are registered; serOut changes only on bit-time boundaries.
- Simultaneous word transfer and shift-register load in the same cycle: the shift register takes the buffered word, and the incoming word fills the buffer.
- start held high across frames: next frame starts the cycle after frame_done, provided start is still high in IDLE.

## Configuration
- SEQ_TX_PARITY_EN defined: a PAR state appends one even-parity bit (XOR of all payload bits actually sent, including zero-filled bits) after the payload, with serOutEn=1.
- SEQ_TX_PARITY_EN undefined: no PAR state; DATA goes straight to GUARD.

## Structure
- Package seq_pkg holds:
  - state enum seq_tx_state_t;
  - constants SEQ_PREAMBLE = 6'b011110 (sent bit 0 first) and SEQ_PREAMBLE_LEN = 6, shared with the detector side.
- One sub-module, seq_bit_tick: BIT_DIV divider producing a one-cycle bit_tick and cleared on start accept.

## Test plan
- PAYLOAD_BITS=16, WORD_W=8, BIT_DIV=1; words 0xA5, 0x3C offered during the preamble; start pulse → serOut = 0,1,1,1,1,0, 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, then 1,1; frame_done once; underrun=0.
- Same, but the second word is withheld → bits 15..8 all 0, underrun=1 and held until the next start.
- BIT_DIV=3 → every bit lasts exactly 3 cycles; frame_done at cycle (6+16+2)·3 after start.
- rst low mid-payload → in the same cycle serOut=1, serOutEn=0, busy=0; a new start yields a clean full preamble.
- With SEQ_TX_PARITY_EN, payload 0xA5, 0x3C (8 ones) → parity bit 0 after the payload; with 0xA5, 0x3D → parity bit 1.
- start pulses during DATA and GUARD are ignored; start held high → back-to-back frames with no idle cycles beyond the guard bits.
